// File: rtl/mem_access_ctrl.sv
// Load/store controller for a word-wide data memory; sub-word stores use read-modify-write.
// Optional alignment checking: define MEM_ACCESS_CTRL_ALIGN_CHK_EN.
module mem_access_ctrl_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] size,
    input  logic [1:0] off,
    input  logic [7:0] old_byte,
    input  logic [7:0] lo_byte,
    input  logic [7:0] hw_byte,
    input  logic [7:0] wd_byte,
    output logic [7:0] new_byte
);
    always_comb begin
        new_byte = old_byte;
        case (size)
            2'b00: if (off == 2'(LANE)) new_byte = lo_byte;
            2'b01: if (off[1] == 1'(LANE / 2)) new_byte = hw_byte;
            2'b10: new_byte = wd_byte;
            default: new_byte = old_byte;
        endcase
    end
endmodule

module mem_access_ctrl #(
    parameter int DM_AW = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      rdata,
    output logic             dm_wena,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic        bad_req;
    logic [1:0]  off_in;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;
    logic        unused_addr;

    // Bits above the memory window wrap around.
    assign unused_addr = ^addr[31:DM_AW+2];

`ifdef MEM_ACCESS_CTRL_ALIGN_CHK_EN
    assign bad_req = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00);
    assign off_in  = addr[1:0];
`else
    // Misaligned offsets are silently rounded down to the access size.
    assign bad_req = (size == 2'b11);
    assign off_in  = (size == 2'b01) ? {addr[1], 1'b0} :
                     (size == 2'b10) ? 2'b00 : addr[1:0];
`endif

    always_comb begin
        ld_b = dm_rdata[{off_q, 3'b000} +: 8];
        ld_h = dm_rdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   ld_val = {{24{sext_q & ld_b[7]}}, ld_b};
            2'b01:   ld_val = {{16{sext_q & ld_h[15]}}, ld_h};
            default: ld_val = dm_rdata;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        mem_access_ctrl_lane #(.LANE(k)) u_lane (
            .size     (size_q),
            .off      (off_q),
            .old_byte (buf_q[8*k +: 8]),
            .lo_byte  (wdata_q[7:0]),
            .hw_byte  (wdata_q[8*(k%2) +: 8]),
            .wd_byte  (wdata_q[8*k +: 8]),
            .new_byte (dm_wdata[8*k +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            dm_wena <= 1'b0;
            dm_addr <= '0;
            rdata   <= '0;
            buf_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_q    <= we;
                    size_q  <= size;
                    sext_q  <= sign_ext;
                    off_q   <= off_in;
                    wdata_q <= wdata;
                    dm_addr <= addr[DM_AW+1:2];
                    busy    <= 1'b1;
                    if (bad_req) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (we && size == 2'b10) begin
                        state   <= WR;
                        dm_wena <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                // dm_wena is low here, so the memory output is valid.
                RD: begin
                    buf_q <= dm_rdata;
                    if (we_q) begin
                        state   <= WR;
                        dm_wena <= 1'b1;
                    end else begin
                        rdata <= ld_val;
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WR: begin
                    dm_wena <= 1'b0;
                    state   <= DONE;
                    done    <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus random accesses against a byte-lane reference model.
module tb_mem_access_ctrl;
    localparam int DM_AW = 11;
    localparam int DEPTH = 1 << DM_AW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic             we = 1'b0;
    logic [1:0]       size = 2'b00;
    logic             sign_ext = 1'b0;
    logic [31:0]      addr = '0;
    logic [31:0]      wdata = '0;
    logic             busy, done, err;
    logic [31:0]      rdata;
    logic             dm_wena;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] exp_rdata = '0;
    int          n_vec = 0;
    int          n_bad = 0;

    mem_access_ctrl #(.DM_AW(DM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .dm_wena(dm_wena),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr];
    always @(negedge clk) if (dm_wena) mem[dm_addr] = dm_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory semantics, computed with shifts and masks.
    function automatic void model(input logic w, input logic [1:0] sz, input logic sx,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output int lat, output int nw, output logic e, output int widx);
        int off;
        int nbytes;
        logic bad;
        logic [31:0] mask, v;
        off  = int'(a % 4);
        widx = int'((a / 4) % DEPTH);
        bad  = (sz == 2'b11);
`ifdef MEM_ACCESS_CTRL_ALIGN_CHK_EN
        if (sz == 2'b01 && off % 2 != 0) bad = 1'b1;
        if (sz == 2'b10 && off != 0) bad = 1'b1;
`else
        if (sz == 2'b01) off = off - off % 2;
        if (sz == 2'b10) off = 0;
`endif
        if (bad) begin
            lat = 1; nw = 0; e = 1'b1;
            return;
        end
        e = 1'b0;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        if (!w) begin
            v = (ref_mem[widx] >> (8 * off)) & mask;
            if (sx && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
            exp_rdata = v;
            lat = 2; nw = 0;
        end else begin
            ref_mem[widx] = (ref_mem[widx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            lat = (nbytes == 4) ? 2 : 3;
            nw = 1;
        end
    endfunction

    task automatic run(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic spam,
                       output logic [31:0] got_rd);
        int exp_lat, exp_nw, widx, lat, nw;
        logic exp_e, got_e;
        model(w, sz, sx, a, wd, exp_lat, exp_nw, exp_e, widx);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        if (spam) begin
            we = 1'b1; size = 2'b10; addr = 32'h18; wdata = 32'hDEAD_BEEF;
        end else begin
            req = 1'b0;
        end
        chk("busy_c1", 32'(busy), 32'd1);
        lat = 0; nw = 0; got_e = 1'bx; got_rd = 'x;
        for (int i = 1; i <= 8; i++) begin
            if (dm_wena) nw++;
            if (done) begin
                lat = i; got_e = err; got_rd = rdata;
                break;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(got_e), 32'(exp_e));
        chk("rdata", got_rd, exp_rdata);
        chk("wena_cycles", 32'(nw), 32'(exp_nw));
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        if (spam) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                chk("spam_no_done", 32'(done), 32'd0);
            end
        end
        chk("mem_word", mem[widx], ref_mem[widx]);
    endtask

    initial begin
        logic [31:0] rd;
        int          nmis;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'h8899_AABB;
        ref_mem[5] = 32'h8899_AABB;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wena", 32'(dm_wena), 32'd0);
        chk("rst_addr", 32'(dm_addr), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, rd);
        chk("ld_word_const", rd, 32'h8899_AABB);
        run(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 1'b0, rd);
        chk("ld_byte_sx_const", rd, 32'hFFFF_FFBB);
        run(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 1'b0, rd);
        chk("ld_byte_zx_const", rd, 32'h0000_00BB);
        run(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0, rd);
        chk("ld_half_sx_const", rd, 32'hFFFF_8899);
        run(1'b0, 2'b01, 1'b1, 32'h15, 32'h0, 1'b0, rd);
`ifndef MEM_ACCESS_CTRL_ALIGN_CHK_EN
        chk("ld_half_misal_const", rd, 32'hFFFF_AABB);
`endif
        run(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 1'b0, rd);
        run(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00CC, 1'b0, rd);
        chk("st_byte_const", mem[5], 32'h8899_CCBB);

        // Reset while a half store sits in RD: abandoned, memory untouched.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h14; wdata = 32'h1234;
        @(posedge clk); #1;
        req = 1'b0;
        chk("rstmid_busy_pre", 32'(busy), 32'd1);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        exp_rdata = '0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rstmid_no_done", 32'(done), 32'd0);
            chk("rstmid_wena", 32'(dm_wena), 32'd0);
        end
        chk("rstmid_mem5", mem[5], 32'h8899_CCBB);

        run(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, rd);
        chk("spam_mem6", mem[6], ref_mem[6]);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, 1'b0, rd);
        end

        nmis = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nmis++;
        chk("mem_all", 32'(nmis), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
